mem_responder: RTL and testbench

- Memory-side responder for the CPU's memory bus (mem_cmd / mem_addr / write_data in, read_data out).
- Provides word RAM, a memory-mapped LED output register and a memory-mapped switch input port.
- Adds a fixed-latency read pipeline with a read_valid strobe, and a sticky error flag for bad accesses.
- Sits at top level between the CPU and board I/O.

---
 rtl/mem_responder.sv | 190 +++++++++++++++++++
 tb/tb_mem_responder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the CPU memory bus. It serves three targets:
//   * a word RAM at addresses 0 .. RAM_WORDS-1
//   * an LED output register at LED_ADDR (writable and readable)
//   * a switch input port at SW_ADDR (read only, 2-flop synchronised)
// Reads come back after a fixed READ_LAT cycles with a one-cycle read_valid
// strobe. Any bad access (unmapped address, write to the switch port, or the
// reserved command) raises a sticky err flag that only reset clears.
//
// Ports:
//   clk        in   1       system clock, rising edge
//   reset      in   1       asynchronous active-high reset
//   mem_cmd    in   2       00 none, 01 read, 10 write, 11 reserved
//   mem_addr   in   ADDR_W  word address
//   write_data in   DATA_W  write payload
//   read_data  out  DATA_W  last returned read result (held between results)
//   read_valid out  1       strobe, high in the cycle a new result appears
//   sw         in   10      raw board switches (asynchronous)
//   led        out  8       LED register
//   err        out  1       sticky bad-access flag
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int                ADDR_W    = 9,
  parameter int                DATA_W    = 16,
  parameter int                RAM_WORDS = 256,
  parameter logic [ADDR_W-1:0] LED_ADDR  = 9'h100,
  parameter logic [ADDR_W-1:0] SW_ADDR   = 9'h140,
  parameter int                READ_LAT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  input  logic [9:0]        sw,
  output logic [7:0]        led,
  output logic              err
);

  localparam int                RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  // One extra bit so the RAM bound compare works even when RAM fills the map.
  localparam logic [ADDR_W:0]   RAM_LIMIT = (ADDR_W+1)'(RAM_WORDS);

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10,
    MRSVD  = 2'b11
  } cmd_e;

  cmd_e               cmd;
  logic               isRam;
  logic               isLed;
  logic               isSw;
  logic [RAM_AW-1:0]  ramIdx;
  logic [DATA_W-1:0]  ramRd;
  logic               ramWe;

  logic [DATA_W-1:0]  ram_q [RAM_WORDS];
  logic [9:0]         swMeta_q;
  logic [9:0]         swSync_q;
  logic [7:0]         led_q;
  logic [7:0]         led_d;
  logic               err_q;
  logic               err_d;

  logic               issueValid;
  logic [DATA_W-1:0]  issueData;

  logic               pipeValid_q [READ_LAT];
  logic [DATA_W-1:0]  pipeData_q  [READ_LAT];
  logic               stageInValid [READ_LAT];
  logic [DATA_W-1:0]  stageInData  [READ_LAT];

  assign cmd    = cmd_e'(mem_cmd);
  // Addresses at or above RAM_WORDS never alias back into the RAM.
  assign isRam  = ({1'b0, mem_addr} < RAM_LIMIT);
  assign isLed  = (mem_addr == LED_ADDR);
  assign isSw   = (mem_addr == SW_ADDR);
  assign ramIdx = mem_addr[RAM_AW-1:0];
  // Combinational read sees every write committed at earlier edges, and not
  // the write being committed at the end of this same cycle.
  assign ramRd  = ram_q[ramIdx];

  // Two-flop synchroniser for the asynchronous board switches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      swMeta_q <= '0;
      swSync_q <= '0;
    end else begin
      swMeta_q <= sw;
      swSync_q <= swMeta_q;
    end
  end

  // Command decode: write side effects, read source selection and error flag.
  always_comb begin
    ramWe      = 1'b0;
    led_d      = led_q;
    err_d      = err_q;
    issueValid = 1'b0;
    issueData  = '0;
    case (cmd)
      MWRITE: begin
        if (isRam) begin
          ramWe = 1'b1;
        end else if (isLed) begin
          led_d = write_data[7:0];
        end else begin
          err_d = 1'b1;
        end
      end
      MREAD: begin
        issueValid = 1'b1;
        if (isRam) begin
          issueData = ramRd;
        end else if (isLed) begin
          issueData[7:0] = led_q;
        end else if (isSw) begin
          issueData[9:0] = swSync_q;
        end else begin
          err_d = 1'b1;
        end
      end
      MRSVD: begin
        err_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // RAM storage is deliberately not reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (ramWe) begin
      ram_q[ramIdx] <= write_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q <= '0;
      err_q <= 1'b0;
    end else begin
      led_q <= led_d;
      err_q <= err_d;
    end
  end

  // Each stage takes the previous stage's contents; stage 0 takes the issue.
  always_comb begin
    for (int i = 0; i < READ_LAT; i++) begin
      if (i == 0) begin
        stageInValid[i] = issueValid;
        stageInData[i]  = issueData;
      end else begin
        stageInValid[i] = pipeValid_q[i-1];
        stageInData[i]  = pipeData_q[i-1];
      end
    end
  end

  // Data only moves with a valid token, so the last stage doubles as the
  // read_data holding register between results. Reset flushes every token.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < READ_LAT; i++) begin
        pipeValid_q[i] <= 1'b0;
        pipeData_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < READ_LAT; i++) begin
        pipeValid_q[i] <= stageInValid[i];
        if (stageInValid[i]) begin
          pipeData_q[i] <= stageInData[i];
        end
      end
    end
  end

  assign read_valid = pipeValid_q[READ_LAT-1];
  assign read_data  = pipeData_q[READ_LAT-1];
  assign led        = led_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//
// Directed bench for mem_responder at READ_LAT = 3. Inputs are driven 1 time
// unit after each rising edge; outputs are sampled on the falling edge by a
// scoreboard monitor or right after an edge by the directed checks. Every
// MREAD pushes its expected data and due cycle into a queue, and the monitor
// pops it when read_valid fires.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  localparam int             LAT      = 3;
  localparam logic [8:0]     LED_ADDR = 9'h100;
  localparam logic [8:0]     SW_ADDR  = 9'h140;
  localparam logic [1:0]     C_NONE   = 2'b00;
  localparam logic [1:0]     C_READ   = 2'b01;
  localparam logic [1:0]     C_WRITE  = 2'b10;
  localparam logic [1:0]     C_RSVD   = 2'b11;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        read_valid;
  logic [9:0]  sw;
  logic [7:0]  led;
  logic        err;

  int          testCount;
  int          failCount;
  int          cycle;
  exp_t        expQ[$];
  logic [15:0] holdModel;
  logic [15:0] ramModel [256];
  logic [7:0]  ledModel;
  logic        errModel;
  logic [9:0]  swSyncModel;

  mem_responder #(
    .ADDR_W    (9),
    .DATA_W    (16),
    .RAM_WORDS (256),
    .LED_ADDR  (LED_ADDR),
    .SW_ADDR   (SW_ADDR),
    .READ_LAT  (LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .read_valid (read_valid),
    .sw         (sw),
    .led        (led),
    .err        (err)
  );

  // Free-running clock with a cycle counter used for result timing.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Expected read result from the bench's own view of the memory map.
  function automatic logic [15:0] expectRead(input logic [8:0] addr);
    logic [15:0] v;
    v = 16'h0000;
    if (addr < 9'd256)          v = ramModel[addr[7:0]];
    else if (addr == LED_ADDR)  v = {8'h00, ledModel};
    else if (addr == SW_ADDR)   v = {6'b0, swSyncModel};
    return v;
  endfunction

  // Drive one command for one cycle and update the reference model.
  task automatic applyStimulus(input logic [1:0] cmd, input logic [8:0] addr,
                               input logic [15:0] data);
    exp_t e;
    mem_cmd    = cmd;
    mem_addr   = addr;
    write_data = data;
    if (cmd == C_READ) begin
      e.data = expectRead(addr);
      e.due  = cycle + LAT;
      expQ.push_back(e);
      if (!(addr < 9'd256 || addr == LED_ADDR || addr == SW_ADDR)) errModel = 1'b1;
    end else if (cmd == C_WRITE) begin
      if (addr < 9'd256)          ramModel[addr[7:0]] = data;
      else if (addr == LED_ADDR)  ledModel = data[7:0];
      else                        errModel = 1'b1;
    end else if (cmd == C_RSVD) begin
      errModel = 1'b1;
    end
    @(posedge clk);
    #1;
    mem_cmd    = C_NONE;
    mem_addr   = '0;
    write_data = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset(input int n);
    reset = 1'b1;
    expQ.delete();
    ledModel = '0;
    errModel = 1'b0;
    swSyncModel = '0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Scoreboard monitor: pops an expectation on every strobe, checks timing,
  // data, the hold value between strobes and flags any missing result.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      holdModel = 16'h0000;
      checkOutput("valid_in_reset", {15'b0, read_valid}, 16'h0000);
    end else if (read_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_valid", {15'b0, read_valid}, 16'h0000);
      end else begin
        e = expQ.pop_front();
        checkOutput("rd_data", read_data, e.data);
        checkOutput("rd_time", 16'(cycle), 16'(e.due));
        holdModel = e.data;
      end
    end else begin
      checkOutput("rd_hold", read_data, holdModel);
      if (expQ.size() > 0 && expQ[0].due <= cycle) begin
        checkOutput("rd_missing", {15'b0, read_valid}, 16'h0001);
        void'(expQ.pop_front());
      end
    end
  end

  // Directed sequence.
  initial begin
    testCount   = 0;
    failCount   = 0;
    cycle       = 0;
    holdModel   = 16'h0000;
    reset       = 1'b1;
    mem_cmd     = C_NONE;
    mem_addr    = '0;
    write_data  = '0;
    sw          = '0;
    ledModel    = '0;
    errModel    = 1'b0;
    swSyncModel = '0;

    doReset(3);
    idle(5);
    checkOutput("reset_read_data", read_data, 16'h0000);
    checkOutput("reset_read_valid", {15'b0, read_valid}, 16'h0000);
    checkOutput("reset_led", {8'h00, led}, 16'h0000);
    checkOutput("reset_err", {15'b0, err}, 16'h0000);

    // Reset one cycle after a read issue: the result must never appear.
    applyStimulus(C_READ, LED_ADDR, 16'h0000);
    doReset(2);
    idle(LAT + 3);
    checkOutput("flushed_valid", {15'b0, read_valid}, 16'h0000);

    // Write then read-after-write on the next cycle.
    applyStimulus(C_WRITE, 9'h005, 16'hABCD);
    applyStimulus(C_READ, 9'h005, 16'h0000);
    idle(LAT + 1);
    checkOutput("raw_hold", read_data, 16'hABCD);

    // LED register write (upper byte dropped) and readback.
    applyStimulus(C_WRITE, LED_ADDR, 16'h12F0);
    checkOutput("led_write", {8'h00, led}, 16'h00F0);
    applyStimulus(C_READ, LED_ADDR, 16'h0000);
    idle(LAT);

    // Switch port: settled value, then a change one cycle before issue.
    sw = 10'h2A5;
    idle(3);
    swSyncModel = 10'h2A5;
    applyStimulus(C_READ, SW_ADDR, 16'h0000);
    sw = 10'h155;
    idle(1);
    applyStimulus(C_READ, SW_ADDR, 16'h0000);
    idle(3);
    swSyncModel = 10'h155;
    applyStimulus(C_READ, SW_ADDR, 16'h0000);
    idle(LAT);

    // Back-to-back reads return in order on consecutive cycles.
    applyStimulus(C_WRITE, 9'h000, 16'h0011);
    applyStimulus(C_WRITE, 9'h001, 16'h0022);
    applyStimulus(C_WRITE, 9'h002, 16'h0033);
    applyStimulus(C_READ, 9'h000, 16'h0000);
    applyStimulus(C_READ, 9'h001, 16'h0000);
    applyStimulus(C_READ, 9'h002, 16'h0000);
    // Read captured at issue is unaffected by a write in the next cycle.
    applyStimulus(C_READ, 9'h000, 16'h0000);
    applyStimulus(C_WRITE, 9'h000, 16'h0099);
    applyStimulus(C_READ, 9'h000, 16'h0000);
    // Top RAM word.
    applyStimulus(C_WRITE, 9'h0FF, 16'hBEEF);
    applyStimulus(C_READ, 9'h0FF, 16'h0000);
    idle(LAT + 1);
    checkOutput("err_still_clear", {15'b0, err}, 16'h0000);

    // Bad accesses set the sticky error flag.
    applyStimulus(C_WRITE, 9'h1FF, 16'h5555);
    checkOutput("err_unmapped_write", {15'b0, err}, {15'b0, errModel});
    applyStimulus(C_RSVD, 9'h005, 16'h7777);
    checkOutput("err_sticky", {15'b0, err}, 16'h0001);
    checkOutput("rsvd_led_unchanged", {8'h00, led}, {8'h00, ledModel});
    applyStimulus(C_READ, 9'h1FF, 16'h0000);
    // Addresses past the RAM must not alias onto RAM words.
    applyStimulus(C_WRITE, 9'h105, 16'hDEAD);
    applyStimulus(C_WRITE, SW_ADDR, 16'h3FF);
    applyStimulus(C_READ, 9'h005, 16'h0000);
    idle(LAT + 1);
    checkOutput("err_still_set", {15'b0, err}, 16'h0001);

    // Reset clears registers and flag but not the RAM.
    doReset(2);
    checkOutput("post_reset_err", {15'b0, err}, 16'h0000);
    checkOutput("post_reset_led", {8'h00, led}, 16'h0000);
    checkOutput("post_reset_read_data", read_data, 16'h0000);
    applyStimulus(C_READ, 9'h005, 16'h0000);
    applyStimulus(C_READ, 9'h0FF, 16'h0000);

    // Bounded drain; anything still queued is a missing result.
    idle(LAT + 3);
    checkOutput("queue_drained", 16'(expQ.size()), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
